// File: rtl/store_port_if.sv
// Store-port bundle: requester-side handshake and payload in, registered cache-side request out.
interface store_port_if #(
  parameter int NR_PORTS   = 2,
  parameter int ADDR_WIDTH = 56,
  parameter int DATA_WIDTH = 64
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NR_PORTS);

  logic [NR_PORTS-1:0]            req_i;
  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NR_PORTS*DATA_WIDTH-1:0] data_i;
  logic [NR_PORTS*BE_W-1:0]       be_i;
  logic [NR_PORTS*2-1:0]          size_i;
  logic [NR_PORTS-1:0]            gnt_o;
  logic                           pause_i;
  logic                           drained_o;
  logic                           data_req_o;
  logic                           data_gnt_i;
  logic [ADDR_WIDTH-1:0]          address_o;
  logic [DATA_WIDTH-1:0]          wdata_o;
  logic [BE_W-1:0]                be_o;
  logic [1:0]                     size_o;
  logic [IDX_W-1:0]               src_id_o;

  modport master (
    output req_i, addr_i, data_i, be_i, size_i, pause_i, data_gnt_i,
    input  gnt_o, drained_o, data_req_o, address_o, wdata_o, be_o, size_o, src_id_o
  );

  modport slave (
    input  req_i, addr_i, data_i, be_i, size_i, pause_i, data_gnt_i,
    output gnt_o, drained_o, data_req_o, address_o, wdata_o, be_o, size_o, src_id_o
  );
endinterface

// File: rtl/store_port_arbiter.sv
// Round-robin arbiter for the single data-cache store port; holds the winning payload
// until the cache grants it and supports pause/drain for fences and flushes.
module store_port_arbiter #(
  parameter int NR_PORTS   = 2,
  parameter int ADDR_WIDTH = 56,
  parameter int DATA_WIDTH = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  store_port_if.slave  bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NR_PORTS);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [1:0]            size_q, size_d;
  logic [IDX_W-1:0]      src_q, src_d;

  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      winner;
  logic                  found;
  logic                  free;
  logic                  accept;
  logic [NR_PORTS-1:0]   gnt;

  // First requester at or after rr_ptr, wrapping at NR_PORTS
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NR_PORTS);
      if (!found && bus.req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Acceptance is masked during reset so no requester sees a grant whose capture is discarded
  always_comb begin
    free     = (state_q == ST_IDLE) || ((state_q == ST_PENDING) && bus.data_gnt_i);
    accept   = free && !bus.pause_i && found && !rst_i;
    gnt      = '0;
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    size_d   = size_q;
    src_d    = src_q;
    if (accept) begin
      gnt[winner] = 1'b1;
      state_d     = ST_PENDING;
      rr_ptr_d    = IDX_W'((int'(winner) + 1) % NR_PORTS);
      addr_d      = bus.addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d     = bus.data_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      be_d        = bus.be_i[int'(winner)*BE_W +: BE_W];
      size_d      = bus.size_i[int'(winner)*2 +: 2];
      src_d       = winner;
    end else if ((state_q == ST_PENDING) && bus.data_gnt_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      size_q   <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      size_q   <= size_d;
      src_q    <= src_d;
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.drained_o  = bus.pause_i && (state_q == ST_IDLE);
  assign bus.data_req_o = (state_q == ST_PENDING);
  assign bus.address_o  = addr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.be_o       = be_q;
  assign bus.size_o     = size_q;
  assign bus.src_id_o   = src_q;
endmodule
